// File: rtl/dica_pkg.sv
// Shared definitions for the hint generator: op codes, FSM states, LFSR constants, op mux.
package dica_pkg;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_NOR  = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;
   localparam logic [2:0] OP_POP  = 3'd6;
   localparam logic [2:0] OP_SNT  = 3'd7;

   localparam logic [7:0] LFSR_POLI    = 8'hB8;
   localparam logic [7:0] LFSR_SEMENTE = 8'hA5;

   localparam int unsigned MAX_W = 16;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      SORTEIA = 2'd1,
      CALCULA = 2'd2
   } estado_t;

   // Bitwise relation between password and guess, evaluated on MAX_W bits and masked to w bits.
   function automatic logic [MAX_W-1:0] aplica_op(input logic [2:0] op,
                                                  input logic [MAX_W-1:0] s,
                                                  input logic [MAX_W-1:0] t,
                                                  input int unsigned w);
      logic [MAX_W-1:0] r;
      logic [MAX_W-1:0] mascara;
      logic [4:0]       pop;
      mascara = MAX_W'((33'd1 << w) - 33'd1);
      pop     = 5'd0;
      for (int unsigned i = 0; i < MAX_W; i++) begin
         if (i < w && s[i] == t[i]) pop = pop + 5'd1;
      end
      case (op)
         OP_AND:  r = s & t;
         OP_OR:   r = s | t;
         OP_NAND: r = ~(s & t);
         OP_NOR:  r = ~(s | t);
         OP_XOR:  r = s ^ t;
         OP_XNOR: r = ~(s ^ t);
         OP_POP:  r = MAX_W'(pop);
         default: r = s & ~t;
      endcase
      return r & mascara;
   endfunction

   // Forced code (out-of-range maps to 0) or LFSR-based code that never repeats the last one.
   function automatic logic [2:0] escolhe_op(input logic [7:0] lfsr,
                                             input logic       fixa,
                                             input logic [2:0] op_fixa,
                                             input logic       ant_valida,
                                             input logic [2:0] op_ant,
                                             input int unsigned num_ops);
      int unsigned r;
      if (fixa) begin
         r = (32'(op_fixa) < num_ops) ? 32'(op_fixa) : 32'd0;
      end else begin
         r = 32'(lfsr) % num_ops;
         if (num_ops > 32'd1 && ant_valida && r == 32'(op_ant)) r = (r + 32'd1) % num_ops;
      end
      return 3'(r);
   endfunction

endpackage

// File: rtl/dica_gerador_if.sv
// Bus between the game control FSM (master) and the hint generator (slave).
interface dica_gerador_if #(
   parameter int unsigned W  = 7,
   parameter int unsigned CW = 7
);
   logic          nova_rodada;
   logic          pedido;
   logic [CW-1:0] cont;
   logic          usar_fixa;
   logic [2:0]    op_fixa;
   logic [W-1:0]  senha_oculta;
   logic [W-1:0]  tentativa;
   logic [W-1:0]  dica;
   logic [2:0]    operacao;
   logic          dica_valida;
   logic          recusado;
   logic          ocupado;
   logic [3:0]    dicas_restantes;

   modport master (
      output nova_rodada, pedido, cont, usar_fixa, op_fixa, senha_oculta, tentativa,
      input  dica, operacao, dica_valida, recusado, ocupado, dicas_restantes
   );

   modport slave (
      input  nova_rodada, pedido, cont, usar_fixa, op_fixa, senha_oculta, tentativa,
      output dica, operacao, dica_valida, recusado, ocupado, dicas_restantes
   );
endinterface

// File: rtl/dica_lfsr.sv
// 8-bit right-shifting Galois LFSR, steps every cycle unless reloaded.
module dica_lfsr
   import dica_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       carregar,
   input  logic [7:0] semente,
   output logic [7:0] estado
);

   // Reload from the round seed, otherwise advance one step.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        estado <= LFSR_SEMENTE;
      else if (carregar) estado <= semente;
      else               estado <= (estado >> 1) ^ (estado[0] ? LFSR_POLI : 8'h00);
   end

endmodule

// File: rtl/dica_gerador.sv
// Clocked hint generator: snapshot, pick an operation, deliver a registered hint within budget.
module dica_gerador
   import dica_pkg::*;
#(
   parameter int unsigned W         = 7,
   parameter int unsigned CW        = 7,
   parameter int unsigned NUM_OPS   = 6,
   parameter int unsigned MAX_DICAS = 3
) (
   input  logic           clk,
   input  logic           reset,
   dica_gerador_if.slave  bus
);

   estado_t      estado;
   logic [W-1:0] s_snap;
   logic [W-1:0] t_snap;
   logic [2:0]   op_sel;
   logic [2:0]   op_ant;
   logic         ant_valida;
   logic [7:0]   lfsr_q;
   logic [2:0]   op_c;
   logic [W-1:0] dica_c;
   logic [7:0]   semente_c;

   dica_lfsr u_lfsr (
      .clk      (clk),
      .reset    (reset),
      .carregar (bus.nova_rodada),
      .semente  (semente_c),
      .estado   (lfsr_q)
   );

   // Operation choice, hint value from the snapshot, and round seed (0 is a dead LFSR state).
   always_comb begin
      op_c      = escolhe_op(lfsr_q, bus.usar_fixa, bus.op_fixa, ant_valida, op_ant, NUM_OPS);
      dica_c    = W'(aplica_op(op_sel, MAX_W'(s_snap), MAX_W'(t_snap), W));
      semente_c = 8'(bus.cont) ^ LFSR_SEMENTE;
      if (semente_c == 8'h00) semente_c = 8'h01;
   end

   // Control FSM with registered outputs; nova_rodada overrides everything.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado              <= OCIOSO;
         s_snap              <= '0;
         t_snap              <= '0;
         op_sel              <= 3'd0;
         op_ant              <= 3'd0;
         ant_valida          <= 1'b0;
         bus.dica            <= '0;
         bus.operacao        <= 3'd0;
         bus.dica_valida     <= 1'b0;
         bus.recusado        <= 1'b0;
         bus.ocupado         <= 1'b0;
         bus.dicas_restantes <= 4'(MAX_DICAS);
      end else if (bus.nova_rodada) begin
         estado              <= OCIOSO;
         ant_valida          <= 1'b0;
         bus.dica            <= '0;
         bus.operacao        <= 3'd0;
         bus.dica_valida     <= 1'b0;
         bus.recusado        <= 1'b0;
         bus.ocupado         <= 1'b0;
         bus.dicas_restantes <= 4'(MAX_DICAS);
      end else begin
         bus.dica_valida <= 1'b0;
         bus.recusado    <= 1'b0;
         case (estado)
            OCIOSO: begin
               if (bus.pedido) begin
                  if (bus.dicas_restantes != 4'd0) begin
                     s_snap      <= bus.senha_oculta;
                     t_snap      <= bus.tentativa;
                     estado      <= SORTEIA;
                     bus.ocupado <= 1'b1;
                  end else begin
                     bus.recusado <= 1'b1;
                  end
               end
            end
            SORTEIA: begin
               op_sel <= op_c;
               estado <= CALCULA;
            end
            CALCULA: begin
               bus.dica            <= dica_c;
               bus.operacao        <= op_sel;
               op_ant              <= op_sel;
               ant_valida          <= 1'b1;
               bus.dica_valida     <= 1'b1;
               bus.dicas_restantes <= bus.dicas_restantes - 4'd1;
               bus.ocupado         <= 1'b0;
               estado              <= OCIOSO;
            end
            default: begin
               estado      <= OCIOSO;
               bus.ocupado <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dica_gerador.sv
// Directed bench for dica_gerador: forced-op table, budget, random mode, drops, async reset.
module tb_dica_gerador;

   typedef struct {
      logic [2:0] op;
      logic [6:0] dica6;
      logic [2:0] oper6;
      logic [6:0] dica8;
      logic [2:0] oper8;
   } vec_t;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   logic [7:0] m_lfsr;
   vec_t tab[8];
   logic [6:0] res_op[6];

   dica_gerador_if #(.W(7), .CW(7)) bus ();
   dica_gerador_if #(.W(7), .CW(7)) b8 ();

   assign b8.nova_rodada  = bus.nova_rodada;
   assign b8.pedido       = bus.pedido;
   assign b8.cont         = bus.cont;
   assign b8.usar_fixa    = bus.usar_fixa;
   assign b8.op_fixa      = bus.op_fixa;
   assign b8.senha_oculta = bus.senha_oculta;
   assign b8.tentativa    = bus.tentativa;

   dica_gerador #(.W(7), .CW(7), .NUM_OPS(6), .MAX_DICAS(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   dica_gerador #(.W(7), .CW(7), .NUM_OPS(8), .MAX_DICAS(3)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (b8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference LFSR: x^8+x^6+x^5+x^4+1 Galois, seeded per round from cont.
   always @(posedge clk or negedge reset) begin
      if (!reset) m_lfsr <= 8'hA5;
      else if (bus.nova_rodada) begin
         if (({1'b0, bus.cont} ^ 8'hA5) == 8'h00) m_lfsr <= 8'h01;
         else m_lfsr <= {1'b0, bus.cont} ^ 8'hA5;
      end else m_lfsr <= {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
   end

   task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic nova();
      bus.nova_rodada = 1'b1;
      step();
      bus.nova_rodada = 1'b0;
   endtask

   // One accepted pedido with latency checks; returns right after the dica_valida edge.
   task automatic pede(input string tag);
      bus.pedido = 1'b1;
      step();
      bus.pedido = 1'b0;
      chk({tag, " ocupado@N"}, 32'(bus.ocupado), 32'd1);
      chk({tag, " valida@N"}, 32'(bus.dica_valida), 32'd0);
      step();
      chk({tag, " valida@N+1"}, 32'(bus.dica_valida), 32'd0);
      step();
      chk({tag, " valida@N+2"}, 32'(bus.dica_valida), 32'd1);
      chk({tag, " ocupado@N+2"}, 32'(bus.ocupado), 32'd0);
   endtask

   initial begin
      logic [7:0] lv;
      logic [2:0] exp_op;
      logic [2:0] prev_op;
      logic       have_prev;
      logic [6:0] dica_ant;
      int         r;

      n_tests = 0;
      n_fail  = 0;
      // s=0x55, t=0x33 expectations for codes 0..5
      res_op[0] = 7'h11; res_op[1] = 7'h77; res_op[2] = 7'h6E;
      res_op[3] = 7'h08; res_op[4] = 7'h66; res_op[5] = 7'h19;
      for (int i = 0; i < 8; i++) begin
         tab[i].op    = 3'(i);
         tab[i].dica6 = (i < 6) ? res_op[i] : 7'h11;
         tab[i].oper6 = (i < 6) ? 3'(i) : 3'd0;
         tab[i].dica8 = (i < 6) ? res_op[i] : 7'h00;
         tab[i].oper8 = 3'(i);
      end
      tab[6].dica8 = 7'h03;
      tab[7].dica8 = 7'h44;

      reset            = 1'b0;
      bus.nova_rodada  = 1'b0;
      bus.pedido       = 1'b0;
      bus.cont         = 7'd0;
      bus.usar_fixa    = 1'b1;
      bus.op_fixa      = 3'd0;
      bus.senha_oculta = 7'h55;
      bus.tentativa    = 7'h33;

      #12;
      chk("rst dica", 32'(bus.dica), 32'd0);
      chk("rst operacao", 32'(bus.operacao), 32'd0);
      chk("rst valida", 32'(bus.dica_valida), 32'd0);
      chk("rst recusado", 32'(bus.recusado), 32'd0);
      chk("rst ocupado", 32'(bus.ocupado), 32'd0);
      chk("rst restantes", 32'(bus.dicas_restantes), 32'd3);
      @(negedge clk);
      reset = 1'b1;
      step();

      // Forced operations, one per fresh round, on both NUM_OPS=6 and NUM_OPS=8
      for (int i = 0; i < 8; i++) begin
         nova();
         bus.op_fixa = tab[i].op;
         pede($sformatf("op%0d", i));
         chk($sformatf("op%0d dica6", i), 32'(bus.dica), 32'(tab[i].dica6));
         chk($sformatf("op%0d oper6", i), 32'(bus.operacao), 32'(tab[i].oper6));
         chk($sformatf("op%0d dica8", i), 32'(b8.dica), 32'(tab[i].dica8));
         chk($sformatf("op%0d oper8", i), 32'(b8.operacao), 32'(tab[i].oper8));
         step();
         chk($sformatf("op%0d valida drop", i), 32'(bus.dica_valida), 32'd0);
      end

      // Budget: three hints then a refusal
      nova();
      chk("budget start", 32'(bus.dicas_restantes), 32'd3);
      for (int i = 0; i < 3; i++) begin
         bus.op_fixa = (i == 0) ? 3'd0 : (i == 1) ? 3'd1 : 3'd4;
         pede($sformatf("budget%0d", i));
         chk($sformatf("budget%0d left", i), 32'(bus.dicas_restantes), 32'(2 - i));
         step();
      end
      dica_ant   = bus.dica;
      chk("budget last dica", 32'(dica_ant), 32'h66);
      bus.pedido = 1'b1;
      step();
      bus.pedido = 1'b0;
      chk("refuse recusado", 32'(bus.recusado), 32'd1);
      chk("refuse ocupado", 32'(bus.ocupado), 32'd0);
      chk("refuse valida", 32'(bus.dica_valida), 32'd0);
      step();
      chk("refuse pulse end", 32'(bus.recusado), 32'd0);
      chk("refuse dica hold", 32'(bus.dica), 32'(dica_ant));
      nova();
      chk("new round left", 32'(bus.dicas_restantes), 32'd3);
      chk("new round dica", 32'(bus.dica), 32'd0);

      // Random mode against the reference LFSR
      bus.usar_fixa = 1'b0;
      have_prev     = 1'b0;
      prev_op       = 3'd0;
      for (int k = 0; k < 200; k++) begin
         if (k % 3 == 0) begin
            bus.cont  = 7'($urandom_range(0, 127));
            nova();
            have_prev = 1'b0;
         end
         bus.pedido = 1'b1;
         step();
         bus.pedido = 1'b0;
         lv = m_lfsr;
         r  = int'(lv) % 6;
         if (have_prev && 3'(r) == prev_op) r = (r + 1) % 6;
         exp_op = 3'(r);
         step();
         step();
         chk($sformatf("rnd%0d valida", k), 32'(bus.dica_valida), 32'd1);
         chk($sformatf("rnd%0d range", k), 32'(bus.operacao < 3'd6), 32'd1);
         chk($sformatf("rnd%0d norepeat", k), 32'(!have_prev || bus.operacao != prev_op), 32'd1);
         chk($sformatf("rnd%0d operacao", k), 32'(bus.operacao), 32'(exp_op));
         chk($sformatf("rnd%0d dica", k), 32'(bus.dica), 32'(res_op[exp_op]));
         prev_op   = exp_op;
         have_prev = 1'b1;
         step();
      end

      // pedido while busy is dropped; snapshot ignores later s/t changes
      bus.usar_fixa = 1'b1;
      bus.op_fixa   = 3'd4;
      nova();
      bus.pedido = 1'b1;
      step();
      bus.senha_oculta = 7'h00;
      bus.tentativa    = 7'h7F;
      step();
      step();
      bus.pedido = 1'b0;
      chk("busy valida", 32'(bus.dica_valida), 32'd1);
      chk("busy snapshot dica", 32'(bus.dica), 32'h66);
      chk("busy left", 32'(bus.dicas_restantes), 32'd2);
      step();
      chk("busy dropped ocupado", 32'(bus.ocupado), 32'd0);
      chk("busy dropped recusado", 32'(bus.recusado), 32'd0);
      step();
      chk("busy dropped left", 32'(bus.dicas_restantes), 32'd2);
      bus.senha_oculta = 7'h55;
      bus.tentativa    = 7'h33;

      // nova_rodada while in SORTEIA aborts the hint
      nova();
      bus.pedido = 1'b1;
      step();
      bus.pedido      = 1'b0;
      bus.nova_rodada = 1'b1;
      step();
      bus.nova_rodada = 1'b0;
      chk("abort ocupado", 32'(bus.ocupado), 32'd0);
      chk("abort valida0", 32'(bus.dica_valida), 32'd0);
      step();
      chk("abort valida1", 32'(bus.dica_valida), 32'd0);
      step();
      chk("abort valida2", 32'(bus.dica_valida), 32'd0);
      chk("abort left", 32'(bus.dicas_restantes), 32'd3);

      // Asynchronous reset while in CALCULA
      bus.op_fixa = 3'd1;
      pede("pre-reset");
      chk("pre-reset dica", 32'(bus.dica), 32'h77);
      step();
      bus.pedido = 1'b1;
      step();
      bus.pedido = 1'b0;
      step();
      #2;
      reset = 1'b0;
      #1;
      chk("arst dica", 32'(bus.dica), 32'd0);
      chk("arst operacao", 32'(bus.operacao), 32'd0);
      chk("arst valida", 32'(bus.dica_valida), 32'd0);
      chk("arst ocupado", 32'(bus.ocupado), 32'd0);
      chk("arst left", 32'(bus.dicas_restantes), 32'd3);
      step();
      chk("arst hold valida", 32'(bus.dica_valida), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step();
      bus.op_fixa = 3'd5;
      pede("post-reset");
      chk("post-reset dica", 32'(bus.dica), 32'h19);
      chk("post-reset operacao", 32'(bus.operacao), 32'd5);
      chk("post-reset left", 32'(bus.dicas_restantes), 32'd2);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
